// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue front end: control codes,
// opcode/funct encodings and the issue state enum.
package alu_pkg;

  localparam logic [3:0] CtrlAnd  = 4'b0000;
  localparam logic [3:0] CtrlOr   = 4'b0001;
  localparam logic [3:0] CtrlAdd  = 4'b0010;
  localparam logic [3:0] CtrlSub  = 4'b0110;
  localparam logic [3:0] CtrlSlt  = 4'b0111;
  localparam logic [3:0] CtrlNor  = 4'b1100;
  localparam logic [3:0] CtrlDiv  = 4'b1110;
  localparam logic [3:0] CtrlMult = 4'b1111;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnMult = 6'b011000;
  localparam logic [5:0] FnDiv  = 6'b011010;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } issue_state_e;

  function automatic logic [31:0] ext_imm(logic [15:0] imm, logic zext);
    return zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: opcode/funct/imm to ALU control code,
// operand-2 source, op class flags and illegal detection.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  output logic [3:0]  ctrl_o,
  output logic        use_imm_o,
  output logic [31:0] imm_ext_o,
  output logic        is_muldiv_o,
  output logic        is_div_o,
  output logic        is_branch_o,
  output logic        is_bne_o,
  output logic        illegal_o
);

  logic zext;

  always_comb begin
    ctrl_o      = CtrlAdd;
    use_imm_o   = 1'b0;
    zext        = 1'b0;
    is_muldiv_o = 1'b0;
    is_div_o    = 1'b0;
    is_branch_o = 1'b0;
    is_bne_o    = 1'b0;
    illegal_o   = 1'b0;
    unique case (opcode_i)
      OpRtype: begin
        unique case (funct_i)
          FnAdd:  ctrl_o = CtrlAdd;
          FnSub:  ctrl_o = CtrlSub;
          FnAnd:  ctrl_o = CtrlAnd;
          FnOr:   ctrl_o = CtrlOr;
          FnNor:  ctrl_o = CtrlNor;
          FnSlt:  ctrl_o = CtrlSlt;
          FnMult: begin
            ctrl_o      = CtrlMult;
            is_muldiv_o = 1'b1;
          end
          FnDiv: begin
            ctrl_o      = CtrlDiv;
            is_muldiv_o = 1'b1;
            is_div_o    = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      OpAddi, OpLw, OpSw: use_imm_o = 1'b1;
      OpSlti: begin
        ctrl_o    = CtrlSlt;
        use_imm_o = 1'b1;
      end
      OpAndi: begin
        ctrl_o    = CtrlAnd;
        use_imm_o = 1'b1;
        zext      = 1'b1;
      end
      OpOri: begin
        ctrl_o    = CtrlOr;
        use_imm_o = 1'b1;
        zext      = 1'b1;
      end
      OpBeq: begin
        ctrl_o      = CtrlSub;
        is_branch_o = 1'b1;
      end
      OpBne: begin
        ctrl_o      = CtrlSub;
        is_branch_o = 1'b1;
        is_bne_o    = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

  assign imm_ext_o = ext_imm(imm_i, zext);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller feeding the ALU operand/control interface and returning
// its registered outcome. Optional macro DIVZERO_TRAP_EN traps div by zero.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned MULDIV_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [5:0]  in_funct,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  input  logic [15:0] in_imm,
  output logic [31:0] alu_data_1,
  output logic [31:0] alu_data_2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_branch_taken,
  output logic        out_illegal
);

  localparam int unsigned CntW = (MULDIV_WAIT > 1) ? $clog2(MULDIV_WAIT) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MULDIV_WAIT - 1);
  localparam bit HasWait = (MULDIV_WAIT != 0);
`ifdef DIVZERO_TRAP_EN
  localparam bit DivZeroTrap = 1'b1;
`else
  localparam bit DivZeroTrap = 1'b0;
`endif

  issue_state_e state_q, state_d;
  logic [31:0]  data_1_q, data_1_d, data_2_q, data_2_d;
  logic [3:0]   ctrl_q, ctrl_d;
  logic         muldiv_q, muldiv_d, branch_q, branch_d, bne_q, bne_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]  result_q, result_d;
  logic         taken_q, taken_d, illegal_q, illegal_d;

  logic [3:0]  dec_ctrl;
  logic        dec_use_imm, dec_is_muldiv, dec_is_div, dec_is_branch, dec_is_bne;
  logic        dec_illegal;
  logic [31:0] dec_imm_ext;
  logic        div_trap, sample;

  alu_op_decode u_decode (
    .opcode_i    (in_opcode),
    .funct_i     (in_funct),
    .imm_i       (in_imm),
    .ctrl_o      (dec_ctrl),
    .use_imm_o   (dec_use_imm),
    .imm_ext_o   (dec_imm_ext),
    .is_muldiv_o (dec_is_muldiv),
    .is_div_o    (dec_is_div),
    .is_branch_o (dec_is_branch),
    .is_bne_o    (dec_is_bne),
    .illegal_o   (dec_illegal)
  );

  assign div_trap = DivZeroTrap && dec_is_div && (in_rt_data == 32'h0);

  always_comb begin
    state_d   = state_q;
    data_1_d  = data_1_q;
    data_2_d  = data_2_q;
    ctrl_d    = ctrl_q;
    muldiv_d  = muldiv_q;
    branch_d  = branch_q;
    bne_d     = bne_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    sample    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (dec_illegal || div_trap) begin
            // Not issued: ALU outputs keep their previous values.
            result_d  = div_trap ? 32'hFFFF_FFFF : 32'h0;
            taken_d   = 1'b0;
            illegal_d = 1'b1;
            state_d   = StDone;
          end else begin
            data_1_d = in_rs_data;
            data_2_d = dec_use_imm ? dec_imm_ext : in_rt_data;
            ctrl_d   = dec_ctrl;
            muldiv_d = dec_is_muldiv;
            branch_d = dec_is_branch;
            bne_d    = dec_is_bne;
            state_d  = StIssue;
          end
        end
      end
      StIssue: begin
        if (muldiv_q && HasWait) begin
          cnt_d   = CntLoad;
          state_d = StWait;
        end else begin
          sample = 1'b1;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          sample = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (sample) begin
      result_d  = alu_result;
      taken_d   = branch_q & (alu_zero ^ bne_q);
      illegal_d = 1'b0;
      state_d   = StDone;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      data_1_q  <= 32'h0;
      data_2_q  <= 32'h0;
      ctrl_q    <= CtrlAdd;
      muldiv_q  <= 1'b0;
      branch_q  <= 1'b0;
      bne_q     <= 1'b0;
      cnt_q     <= '0;
      result_q  <= 32'h0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_1_q  <= data_1_d;
      data_2_q  <= data_2_d;
      ctrl_q    <= ctrl_d;
      muldiv_q  <= muldiv_d;
      branch_q  <= branch_d;
      bne_q     <= bne_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready         = (state_q == StIdle);
  assign out_valid        = (state_q == StDone);
  assign alu_data_1       = data_1_q;
  assign alu_data_2       = data_2_q;
  assign alu_ctrl         = ctrl_q;
  assign out_result       = result_q;
  assign out_branch_taken = taken_q;
  assign out_illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU on the far side of
// the interface and an instruction-level reference model.
module tb_alu_issue_ctrl;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [5:0]  in_opcode, in_funct;
  logic [31:0] in_rs_data, in_rt_data;
  logic [15:0] in_imm;
  logic [31:0] alu_data_1, alu_data_2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_branch_taken, out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.MULDIV_WAIT(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_opcode        (in_opcode),
    .in_funct         (in_funct),
    .in_rs_data       (in_rs_data),
    .in_rt_data       (in_rt_data),
    .in_imm           (in_imm),
    .alu_data_1       (alu_data_1),
    .alu_data_2       (alu_data_2),
    .alu_ctrl         (alu_ctrl),
    .alu_result       (alu_result),
    .alu_zero         (alu_zero),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_branch_taken (out_branch_taken),
    .out_illegal      (out_illegal)
  );

  // Behavioural ALU consuming the DUT's operand/control outputs.
  always_comb begin
    case (alu_ctrl)
      4'b0010: alu_result = alu_data_1 + alu_data_2;
      4'b0110: alu_result = alu_data_1 - alu_data_2;
      4'b0000: alu_result = alu_data_1 & alu_data_2;
      4'b0001: alu_result = alu_data_1 | alu_data_2;
      4'b1100: alu_result = ~(alu_data_1 | alu_data_2);
      4'b0111: alu_result = ($signed(alu_data_1) < $signed(alu_data_2)) ? 32'hFFFF_FFFF : 32'h0;
      4'b1111: alu_result = alu_data_1 * alu_data_2;
      4'b1110: alu_result = (alu_data_2 == 32'h0) ? 32'h0 : alu_data_1 / alu_data_2;
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  typedef struct packed {
    bit          ill;
    bit          issued;
    bit          br;
    logic [3:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] res;
    int          lat;
  } exp_t;

  typedef struct packed {
    bit          ready_before;
    logic [3:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    int          lat;
    logic [31:0] res;
    logic        br;
    logic        ill;
    bit          alu_stable;
    bit          done_stable;
    bit          released;
  } obs_t;

  // Instruction-level reference: what the outcome of one instruction should be.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [15:0] imm);
    exp_t e;
    logic [31:0] sx, zx;
    sx = {{16{imm[15]}}, imm};
    zx = {16'h0000, imm};
    e = '0;
    e.d1 = rs;
    e.lat = 2;
    if (op == 6'h00) begin
      e.d2 = rt;
      case (fn)
        6'h20: begin e.ctrl = 4'b0010; e.res = rs + rt; end
        6'h22: begin e.ctrl = 4'b0110; e.res = rs - rt; end
        6'h24: begin e.ctrl = 4'b0000; e.res = rs & rt; end
        6'h25: begin e.ctrl = 4'b0001; e.res = rs | rt; end
        6'h27: begin e.ctrl = 4'b1100; e.res = ~(rs | rt); end
        6'h2a: begin
          e.ctrl = 4'b0111;
          e.res = ($signed(rs) < $signed(rt)) ? 32'hFFFF_FFFF : 32'h0;
        end
        6'h18: begin e.ctrl = 4'b1111; e.res = rs * rt; e.lat = 2 + W; end
        6'h1a: begin
          e.ctrl = 4'b1110;
          e.res = (rt == 32'h0) ? 32'h0 : rs / rt;
          e.lat = 2 + W;
        end
        default: e.ill = 1'b1;
      endcase
    end else begin
      case (op)
        6'h08, 6'h23, 6'h2b: begin e.ctrl = 4'b0010; e.d2 = sx; e.res = rs + sx; end
        6'h0a: begin
          e.ctrl = 4'b0111;
          e.d2 = sx;
          e.res = ($signed(rs) < $signed(sx)) ? 32'hFFFF_FFFF : 32'h0;
        end
        6'h0c: begin e.ctrl = 4'b0000; e.d2 = zx; e.res = rs & zx; end
        6'h0d: begin e.ctrl = 4'b0001; e.d2 = zx; e.res = rs | zx; end
        6'h04: begin e.ctrl = 4'b0110; e.d2 = rt; e.res = rs - rt; e.br = (rs == rt); end
        6'h05: begin e.ctrl = 4'b0110; e.d2 = rt; e.res = rs - rt; e.br = (rs != rt); end
        default: e.ill = 1'b1;
      endcase
    end
    if (e.ill) begin
      e.res = 32'h0;
      e.br = 1'b0;
      e.lat = 1;
    end
`ifdef DIVZERO_TRAP_EN
    if (op == 6'h00 && fn == 6'h1a && rt == 32'h0) begin
      e.ill = 1'b1;
      e.res = 32'hFFFF_FFFF;
      e.lat = 1;
    end
`endif
    e.issued = !e.ill;
    return e;
  endfunction

  // Drives one instruction, observes the DUT through the full handshake.
  task automatic do_op(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm, input int hold,
                       output obs_t o);
    o = '0;
    @(negedge clk);
    o.ready_before = (in_ready === 1'b1);
    in_valid = 1'b1;
    in_opcode = op;
    in_funct = fn;
    in_rs_data = rs;
    in_rt_data = rt;
    in_imm = imm;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    o.ctrl = alu_ctrl;
    o.d1 = alu_data_1;
    o.d2 = alu_data_2;
    o.lat = 1;
    o.alu_stable = 1'b1;
    while (out_valid !== 1'b1 && o.lat < 100) begin
      if (alu_ctrl !== o.ctrl || alu_data_1 !== o.d1 || alu_data_2 !== o.d2 ||
          in_ready !== 1'b0) o.alu_stable = 1'b0;
      @(posedge clk);
      #1;
      o.lat++;
    end
    o.res = out_result;
    o.br = out_branch_taken;
    o.ill = out_illegal;
    o.done_stable = (out_valid === 1'b1);
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== o.res ||
          out_branch_taken !== o.br || out_illegal !== o.ill || alu_ctrl !== o.ctrl)
        o.done_stable = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    o.released = (out_valid === 1'b0 && in_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_opcode = '0;
    in_funct = '0;
    in_rs_data = '0;
    in_rt_data = '0;
    in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h want 0", out_result); end
    checks++; if (out_branch_taken !== 1'b0) begin errors++; $display("FAIL reset_branch got %b want 0", out_branch_taken); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", out_illegal); end
    checks++; if (alu_ctrl !== 4'b0010) begin errors++; $display("FAIL reset_alu_ctrl got %b want 0010", alu_ctrl); end
    checks++; if (alu_data_1 !== 32'h0 || alu_data_2 !== 32'h0) begin
      errors++; $display("FAIL reset_alu_data got %h/%h want 0/0", alu_data_1, alu_data_2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    obs_t o;
    do_op(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 0, o);
    checks++; if (o.ctrl !== 4'b0010) begin errors++; $display("FAIL add_ctrl got %b want 0010", o.ctrl); end
    checks++; if (o.res !== 32'd12) begin errors++; $display("FAIL add_result got %0d want 12", o.res); end
    checks++; if (o.lat != 2) begin errors++; $display("FAIL add_latency got %0d want 2", o.lat); end
    checks++; if (o.br !== 1'b0 || o.ill !== 1'b0) begin
      errors++; $display("FAIL add_flags got br=%b ill=%b want 0/0", o.br, o.ill);
    end
    checks++; if (!o.released) begin errors++; $display("FAIL add_release got 0 want 1"); end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [3] = '{6'h04, 6'h05, 6'h05};
    logic [31:0] rss [3] = '{32'h1234, 32'd3, 32'd9};
    logic [31:0] rts [3] = '{32'h1234, 32'd4, 32'd9};
    bit          tk  [3] = '{1'b1, 1'b1, 1'b0};
    obs_t o;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], 6'h00, rss[i], rts[i], 16'h0004, 0, o);
      checks++; if (o.ctrl !== 4'b0110) begin errors++; $display("FAIL branch%0d_ctrl got %b want 0110", i, o.ctrl); end
      checks++; if (o.br !== tk[i]) begin errors++; $display("FAIL branch%0d_taken got %b want %b", i, o.br, tk[i]); end
      checks++; if (o.lat != 2) begin errors++; $display("FAIL branch%0d_latency got %0d want 2", i, o.lat); end
    end
  endtask

  task automatic test_muldiv();
    obs_t o;
    do_op(6'h00, 6'h18, 32'd6, 32'd7, 16'h0, 0, o);
    checks++; if (o.ctrl !== 4'b1111) begin errors++; $display("FAIL mult_ctrl got %b want 1111", o.ctrl); end
    checks++; if (!o.alu_stable) begin errors++; $display("FAIL mult_hold got unstable want stable"); end
    checks++; if (o.lat != 2 + W) begin errors++; $display("FAIL mult_latency got %0d want %0d", o.lat, 2 + W); end
    checks++; if (o.res !== 32'd42) begin errors++; $display("FAIL mult_result got %0d want 42", o.res); end
    do_op(6'h00, 6'h1a, 32'd100, 32'd7, 16'h0, 0, o);
    checks++; if (o.ctrl !== 4'b1110) begin errors++; $display("FAIL div_ctrl got %b want 1110", o.ctrl); end
    checks++; if (o.res !== 32'd14) begin errors++; $display("FAIL div_result got %0d want 14", o.res); end
  endtask

  task automatic test_imm();
    obs_t o;
    do_op(6'h08, 6'h3f, 32'd10, 32'h5555, 16'hFFFF, 0, o);
    checks++; if (o.d2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_data2 got %h want ffffffff", o.d2); end
    checks++; if (o.res !== 32'd9) begin errors++; $display("FAIL addi_result got %0d want 9", o.res); end
    do_op(6'h0d, 6'h00, 32'h0000_000F, 32'h0, 16'h8000, 0, o);
    checks++; if (o.d2 !== 32'h0000_8000) begin errors++; $display("FAIL ori_data2 got %h want 00008000", o.d2); end
    checks++; if (o.res !== 32'h0000_800F) begin errors++; $display("FAIL ori_result got %h want 0000800f", o.res); end
  endtask

  task automatic test_illegal();
    obs_t o;
    do_op(6'h00, 6'h3f, 32'd1, 32'd2, 16'h0, 5, o);
    checks++; if (o.lat != 1) begin errors++; $display("FAIL illegal_latency got %0d want 1", o.lat); end
    checks++; if (o.ill !== 1'b1 || o.res !== 32'h0) begin
      errors++; $display("FAIL illegal_outcome got ill=%b res=%h want 1/0", o.ill, o.res);
    end
    checks++; if (!o.done_stable) begin errors++; $display("FAIL illegal_hold got unstable want stable"); end
    checks++; if (!o.released) begin errors++; $display("FAIL illegal_release got 0 want 1"); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(negedge clk);
    in_valid = 1'b1;
    in_opcode = 6'h00;
    in_funct = 6'h1a;
    in_rs_data = 32'd100;
    in_rt_data = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_handshake got v=%b r=%b want 0/1", out_valid, in_ready);
    end
    checks++; if (alu_ctrl !== 4'b0010 || alu_data_1 !== 32'h0) begin
      errors++; $display("FAIL midreset_alu got ctrl=%b d1=%h want 0010/0", alu_ctrl, alu_data_1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(6'h00, 6'h20, 32'd20, 32'd22, 16'h0, 0, o);
    checks++; if (o.res !== 32'd42 || o.lat != 2) begin
      errors++; $display("FAIL midreset_next got res=%0d lat=%0d want 42/2", o.res, o.lat);
    end
  endtask

  task automatic test_divzero();
    obs_t o;
    exp_t e;
    e = model(6'h00, 6'h1a, 32'd55, 32'd0, 16'h0);
    do_op(6'h00, 6'h1a, 32'd55, 32'd0, 16'h0, 1, o);
    checks++; if (o.res !== e.res || o.ill !== e.ill) begin
      errors++; $display("FAIL divzero_outcome got res=%h ill=%b want %h/%b", o.res, o.ill, e.res, e.ill);
    end
    checks++; if (o.lat != e.lat) begin errors++; $display("FAIL divzero_latency got %0d want %0d", o.lat, e.lat); end
  endtask

  task automatic test_random();
    logic [11:0] tbl [19] = '{
      {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h27},
      {6'h00, 6'h2a}, {6'h00, 6'h18}, {6'h00, 6'h1a}, {6'h00, 6'h3f}, {6'h08, 6'h00},
      {6'h23, 6'h00}, {6'h2b, 6'h00}, {6'h0a, 6'h00}, {6'h0c, 6'h00}, {6'h0d, 6'h00},
      {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h3f, 6'h00}, {6'h02, 6'h00}};
    logic [11:0] sel;
    logic [3:0]  m_ctrl, x_ctrl;
    logic [31:0] m_d1, m_d2, x_d1, x_d2, rs, rt;
    logic [15:0] imm;
    obs_t o;
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ctrl = 4'b0010;
    m_d1 = 32'h0;
    m_d2 = 32'h0;
    for (int i = 0; i < 150; i++) begin
      sel = tbl[$urandom_range(0, 18)];
      rs = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      if (sel[5:0] == 6'h1a) rt = $urandom_range(0, 40);
      imm = 16'($urandom);
      e = model(sel[11:6], sel[5:0], rs, rt, imm);
      do_op(sel[11:6], sel[5:0], rs, rt, imm, $urandom_range(0, 2), o);
      x_ctrl = e.issued ? e.ctrl : m_ctrl;
      x_d1 = e.issued ? e.d1 : m_d1;
      x_d2 = e.issued ? e.d2 : m_d2;
      checks++; if (!o.ready_before) begin errors++; $display("FAIL rand%0d_in_ready got 0 want 1", i); end
      checks++; if (o.ctrl !== x_ctrl || o.d1 !== x_d1 || o.d2 !== x_d2) begin
        errors++;
        $display("FAIL rand%0d_alu got %b/%h/%h want %b/%h/%h", i, o.ctrl, o.d1, o.d2, x_ctrl, x_d1, x_d2);
      end
      checks++; if (o.res !== e.res || o.ill !== e.ill || o.br !== e.br) begin
        errors++;
        $display("FAIL rand%0d_out op=%h got %h/%b/%b want %h/%b/%b", i, sel, o.res, o.ill, o.br,
                 e.res, e.ill, e.br);
      end
      checks++; if (o.lat != e.lat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, o.lat, e.lat); end
      checks++; if (!o.alu_stable || !o.done_stable || !o.released) begin
        errors++;
        $display("FAIL rand%0d_stability got %b%b%b want 111", i, o.alu_stable, o.done_stable, o.released);
      end
      if (e.issued) begin
        m_ctrl = e.ctrl;
        m_d1 = e.d1;
        m_d2 = e.d2;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_muldiv();
    test_imm();
    test_illegal();
    test_reset_mid();
    test_divzero();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
